// File: rtl/rocket_table_ctrl.sv
// Writer side of the rocket object table: launches rockets into free slots, steps every
// active rocket once per frame with gravity, and retires rockets on a hit or off-screen.
module rocket_table_ctrl #(
    parameter int NSLOT   = 4,
    parameter int GRAVITY = 1,
    parameter int VY_MAX  = 24,
    parameter int SPR_W   = 18
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_tick,
    input  logic                 launch_valid,
    output logic                 launch_ready,
    input  logic [5:0]           launch_id,
    input  logic [9:0]           launch_x,
    input  logic [9:0]           launch_y,
    input  logic [5:0]           launch_vx,
    input  logic [7:0]           launch_vy,
    input  logic                 hit_valid,
    input  logic [2:0]           hit_slot,
    output logic [NSLOT*32-1:0]  table_val,
    output logic                 busy
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_UPDATE = 1'b1
    } state_e;

    localparam logic [2:0]         LAST_SLOT = 3'(NSLOT - 1);
    localparam logic signed [11:0] X_MIN     = 12'(SPR_W);
    localparam logic signed [11:0] X_MAX     = 12'(639 + SPR_W);
    localparam logic signed [11:0] Y_MAX     = 12'sd479;
    localparam logic signed [11:0] GRAV      = 12'(GRAVITY);
    localparam logic signed [11:0] VY_SAT    = 12'(VY_MAX);

    state_e      state_q, state_d;
    logic [2:0]  slot_q, slot_d;
    logic        pending_q, pending_d;

    logic [31:0] entry_q [NSLOT];
    logic [31:0] entry_d [NSLOT];
    logic [5:0]  vx_q    [NSLOT];
    logic [5:0]  vx_d    [NSLOT];
    logic [7:0]  vy_q    [NSLOT];
    logic [7:0]  vy_d    [NSLOT];

    logic [NSLOT-1:0] hit_mask;
    logic [NSLOT-1:0] free_mask;
    logic [2:0]       alloc_idx;
    logic             launch_fire;
    logic             launch_store;

    logic [5:0]         cur_id;
    logic [9:0]         cur_x;
    logic [9:0]         cur_y;
    logic [5:0]         cur_vx;
    logic [7:0]         cur_vy;
    logic               visit_active;
    logic signed [11:0] x_n;
    logic signed [11:0] y_n;
    logic signed [11:0] vy_sum;
    logic [7:0]         vy_n;
    logic               retire;

    // NOTE: every always_comb output gets a default before any branch, so no latches form.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        pending_d = pending_q;
        case (state_q)
            S_IDLE: begin
                if (frame_tick || pending_q) begin
                    state_d   = S_UPDATE;
                    slot_d    = '0;
                    pending_d = 1'b0;
                end
            end
            S_UPDATE: begin
                if (frame_tick) pending_d = 1'b1;
                if (slot_q == LAST_SLOT) state_d = S_IDLE;
                else                     slot_d  = slot_q + 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A slot being hit this cycle counts as occupied so a launch never lands on it.
    always_comb begin
        hit_mask  = '0;
        free_mask = '0;
        alloc_idx = '0;
        for (int k = 0; k < NSLOT; k++) begin
            hit_mask[k]  = hit_valid && (hit_slot == 3'(k));
            free_mask[k] = (entry_q[k][31:26] == 6'd0) && !hit_mask[k];
        end
        for (int k = NSLOT - 1; k >= 0; k--) begin
            if (free_mask[k]) alloc_idx = 3'(k);
        end
    end

    assign launch_ready = !Reset && (state_q == S_IDLE) && !pending_q && !frame_tick && (|free_mask);
    assign launch_fire  = launch_valid && launch_ready;
    assign launch_store = launch_fire && (launch_id != 6'd0);
    assign busy         = (state_q == S_UPDATE);

    always_comb begin
        cur_id = '0;
        cur_x  = '0;
        cur_y  = '0;
        cur_vx = '0;
        cur_vy = '0;
        for (int k = 0; k < NSLOT; k++) begin
            if (slot_q == 3'(k)) begin
                cur_id = entry_q[k][31:26];
                cur_x  = entry_q[k][23:14];
                cur_y  = entry_q[k][13:4];
                cur_vx = vx_q[k];
                cur_vy = vy_q[k];
            end
        end
        visit_active = (state_q == S_UPDATE) && (cur_id != 6'd0);
        x_n    = {2'b00, cur_x} + {{6{cur_vx[5]}}, cur_vx};
        y_n    = {2'b00, cur_y} + {{4{cur_vy[7]}}, cur_vy};
        vy_sum = {{4{cur_vy[7]}}, cur_vy} + GRAV;
        vy_n   = (vy_sum > VY_SAT) ? VY_SAT[7:0] : vy_sum[7:0];
        retire = (x_n < X_MIN) || (x_n > X_MAX) || (y_n < 12'sd0) || (y_n > Y_MAX);
    end

    // Per-slot priority: hit, then the frame step of the visited slot, then a launch.
    always_comb begin
        for (int k = 0; k < NSLOT; k++) begin
            entry_d[k] = entry_q[k];
            vx_d[k]    = vx_q[k];
            vy_d[k]    = vy_q[k];
            if (hit_mask[k]) begin
                entry_d[k] = '0;
            end else if (visit_active && (slot_q == 3'(k))) begin
                if (retire) begin
                    entry_d[k] = '0;
                end else begin
                    entry_d[k] = {cur_id, 2'b00, x_n[9:0], y_n[9:0], 4'b0000};
                    vy_d[k]    = vy_n;
                end
            end else if (launch_store && (alloc_idx == 3'(k))) begin
                entry_d[k] = {launch_id, 2'b00, launch_x, launch_y, 4'b0000};
                vx_d[k]    = launch_vx;
                vy_d[k]    = launch_vy;
            end
        end
    end

    always_comb begin
        table_val = '0;
        for (int k = 0; k < NSLOT; k++) begin
            table_val[32*k +: 32] = entry_q[k];
        end
    end

    // NOTE: the table arrays are reset too, so no stale rocket survives a mid-frame reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            slot_q    <= '0;
            pending_q <= 1'b0;
            entry_q   <= '{default: '0};
            vx_q      <= '{default: '0};
            vy_q      <= '{default: '0};
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            pending_q <= pending_d;
            entry_q   <= entry_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
        end
    end

endmodule

// File: tb/tb_rocket_table_ctrl.sv
// Self-checking bench for rocket_table_ctrl: directed sequences, a vector table of
// single-frame moves, and a randomized run against a slot-level reference model.
module tb_rocket_table_ctrl;

    localparam int NSLOT   = 4;
    localparam int GRAVITY = 1;
    localparam int VY_MAX  = 24;
    localparam int SPR_W   = 18;

    logic                 Clk          = 1'b0;
    logic                 Reset        = 1'b1;
    logic                 frame_tick   = 1'b0;
    logic                 launch_valid = 1'b0;
    logic                 launch_ready;
    logic [5:0]           launch_id    = '0;
    logic [9:0]           launch_x     = '0;
    logic [9:0]           launch_y     = '0;
    logic [5:0]           launch_vx    = '0;
    logic [7:0]           launch_vy    = '0;
    logic                 hit_valid    = 1'b0;
    logic [2:0]           hit_slot     = '0;
    logic [NSLOT*32-1:0]  table_val;
    logic                 busy;

    int n_cmp = 0;
    int n_bad = 0;

    rocket_table_ctrl #(
        .NSLOT(NSLOT), .GRAVITY(GRAVITY), .VY_MAX(VY_MAX), .SPR_W(SPR_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .launch_valid(launch_valid), .launch_ready(launch_ready),
        .launch_id(launch_id), .launch_x(launch_x), .launch_y(launch_y),
        .launch_vx(launch_vx), .launch_vy(launch_vy),
        .hit_valid(hit_valid), .hit_slot(hit_slot),
        .table_val(table_val), .busy(busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int x, y, vx, vy;
        int ex, ey;
        bit alive;
    } vec_t;

    // reference model of the table, one record per slot (id 0 = free)
    int m_id [NSLOT];
    int m_x  [NSLOT];
    int m_y  [NSLOT];
    int m_vx [NSLOT];
    int m_vy [NSLOT];

    function automatic logic [31:0] mk_entry(input int id, input int x, input int y);
        return {6'(id), 2'b00, 10'(x), 10'(y), 4'b0000};
    endfunction

    function automatic logic [31:0] slot_of(input int k);
        return table_val[32*k +: 32];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset        = 1'b1;
        frame_tick   = 1'b0;
        launch_valid = 1'b0;
        hit_valid    = 1'b0;
        repeat (2) step();
        Reset = 1'b0;
        step();
    endtask

    task automatic do_launch(input int id, input int x, input int y, input int vx, input int vy);
        bit ok;
        ok           = 1'b0;
        launch_id    = 6'(id);
        launch_x     = 10'(x);
        launch_y     = 10'(y);
        launch_vx    = 6'(vx);
        launch_vy    = 8'(vy);
        launch_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (launch_ready === 1'b1) begin
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        launch_valid = 1'b0;
        check("launch_accepted", {31'b0, ok}, 32'd1);
    endtask

    task automatic do_frame(output int cycles);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            step();
        end
    endtask

    task automatic model_frame();
        for (int k = 0; k < NSLOT; k++) begin
            if (m_id[k] != 0) begin
                int nx, ny, nvy;
                nx  = m_x[k] + m_vx[k];
                ny  = m_y[k] + m_vy[k];
                nvy = m_vy[k] + GRAVITY;
                if (nvy > VY_MAX) nvy = VY_MAX;
                if (nx < SPR_W || nx > 639 + SPR_W || ny < 0 || ny > 479) begin
                    m_id[k] = 0;
                end else begin
                    m_x[k]  = nx;
                    m_y[k]  = ny;
                    m_vy[k] = nvy;
                end
            end
        end
    endtask

    initial begin
        vec_t vecs[11];
        int   cyc;
        int   xs[3];
        int   ys[3];
        bit   busy_exp[11];

        vecs[0]  = '{x:100, y:200, vx:3,  vy:-4, ex:103, ey:196, alive:1'b1};
        vecs[1]  = '{x:20,  y:100, vx:-5, vy:0,  ex:0,   ey:0,   alive:1'b0};
        vecs[2]  = '{x:20,  y:100, vx:-2, vy:0,  ex:18,  ey:100, alive:1'b1};
        vecs[3]  = '{x:657, y:100, vx:0,  vy:0,  ex:657, ey:100, alive:1'b1};
        vecs[4]  = '{x:657, y:100, vx:1,  vy:0,  ex:0,   ey:0,   alive:1'b0};
        vecs[5]  = '{x:300, y:470, vx:0,  vy:12, ex:0,   ey:0,   alive:1'b0};
        vecs[6]  = '{x:300, y:470, vx:0,  vy:9,  ex:300, ey:479, alive:1'b1};
        vecs[7]  = '{x:300, y:3,   vx:0,  vy:-3, ex:300, ey:0,   alive:1'b1};
        vecs[8]  = '{x:300, y:3,   vx:0,  vy:-4, ex:0,   ey:0,   alive:1'b0};
        vecs[9]  = '{x:1000,y:100, vx:0,  vy:0,  ex:0,   ey:0,   alive:1'b0};
        vecs[10] = '{x:30,  y:450, vx:-7, vy:20, ex:23,  ey:470, alive:1'b1};

        // ---- 1: reset state and first launch
        #2;
        check("rst_ready", {31'b0, launch_ready}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        for (int k = 0; k < NSLOT; k++) check($sformatf("rst_slot%0d", k), slot_of(k), 32'd0);
        step();
        Reset = 1'b0;
        step();
        #1;
        check("t1_ready_before", {31'b0, launch_ready}, 32'd1);
        do_launch(5, 100, 200, 3, -4);
        check("t1_slot0", slot_of(0), mk_entry(5, 100, 200));
        #1;
        check("t1_ready_after", {31'b0, launch_ready}, 32'd1);

        // ---- 2: three frames with gravity
        xs = '{103, 106, 109};
        ys = '{196, 193, 191};
        for (int f = 0; f < 3; f++) begin
            do_frame(cyc);
            check($sformatf("t2_busy_cycles%0d", f), 32'(cyc), 32'(NSLOT));
            check($sformatf("t2_slot0_f%0d", f), slot_of(0), mk_entry(5, xs[f], ys[f]));
        end

        // ---- 3: full table, hits, dropped id 0, hit-during-launch allocation
        do_launch(1, 200, 100, 0, 0);
        do_launch(2, 300, 100, 0, 0);
        do_launch(3, 400, 100, 0, 0);
        check("t3_slot1", slot_of(1), mk_entry(1, 200, 100));
        check("t3_slot3", slot_of(3), mk_entry(3, 400, 100));
        launch_valid = 1'b1;
        #1;
        check("t3_ready_full", {31'b0, launch_ready}, 32'd0);
        launch_valid = 1'b0;
        hit_valid = 1'b1;
        hit_slot  = 3'd5;
        step();
        hit_valid = 1'b0;
        check("t3_hit_oob_ignored", slot_of(2), mk_entry(2, 300, 100));
        hit_valid = 1'b1;
        hit_slot  = 3'd2;
        step();
        hit_valid = 1'b0;
        check("t3_hit_slot2", slot_of(2), 32'd0);
        #1;
        check("t3_ready_after_hit", {31'b0, launch_ready}, 32'd1);
        do_launch(9, 50, 60, 0, 0);
        check("t3_refill_slot2", slot_of(2), mk_entry(9, 50, 60));
        hit_valid = 1'b1;
        hit_slot  = 3'd3;
        step();
        hit_valid = 1'b0;
        do_launch(0, 70, 80, 0, 0);
        check("t3_id0_dropped", slot_of(3), 32'd0);
        launch_id    = 6'd11;
        launch_x     = 10'd70;
        launch_y     = 10'd80;
        launch_vx    = '0;
        launch_vy    = '0;
        launch_valid = 1'b1;
        hit_valid    = 1'b1;
        hit_slot     = 3'd2;
        #1;
        check("t3_ready_hit_launch", {31'b0, launch_ready}, 32'd1);
        step();
        launch_valid = 1'b0;
        hit_valid    = 1'b0;
        check("t3_hit_wins_slot2", slot_of(2), 32'd0);
        check("t3_launch_skips_hit", slot_of(3), mk_entry(11, 70, 80));

        // ---- 4: single-frame vector table, including retire boundaries
        foreach (vecs[i]) begin
            do_reset();
            do_launch(i + 1, vecs[i].x, vecs[i].y, vecs[i].vx, vecs[i].vy);
            do_frame(cyc);
            check($sformatf("t4_v%0d_busy", i), 32'(cyc), 32'(NSLOT));
            check($sformatf("t4_v%0d_slot0", i), slot_of(0),
                  vecs[i].alive ? mk_entry(i + 1, vecs[i].ex, vecs[i].ey) : 32'd0);
        end

        // vy saturation: start vy=30, next frame steps by VY_MAX
        do_reset();
        do_launch(40, 300, 10, 0, 30);
        do_frame(cyc);
        check("t4_sat_f0", slot_of(0), mk_entry(40, 300, 40));
        do_frame(cyc);
        check("t4_sat_f1", slot_of(0), mk_entry(40, 300, 64));

        // ---- 5: queued tick, lost third tick, launch held until idle
        do_reset();
        do_launch(5, 100, 200, 3, -4);
        launch_id    = 6'd7;
        launch_x     = 10'd500;
        launch_y     = 10'd300;
        launch_vx    = '0;
        launch_vy    = '0;
        launch_valid = 1'b1;
        frame_tick   = 1'b1;
        #1;
        check("t5_ready_on_tick", {31'b0, launch_ready}, 32'd0);
        step();
        busy_exp = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 1; i <= 10; i++) begin
            frame_tick = (i <= 2);
            #1;
            check($sformatf("t5_busy_c%0d", i), {31'b0, busy}, {31'b0, busy_exp[i]});
            check($sformatf("t5_ready_c%0d", i), {31'b0, launch_ready}, (i == 10) ? 32'd1 : 32'd0);
            step();
        end
        launch_valid = 1'b0;
        frame_tick   = 1'b0;
        check("t5_two_frames_only", slot_of(0), mk_entry(5, 106, 193));
        check("t5_launch_after", slot_of(1), mk_entry(7, 500, 300));
        check("t5_idle", {31'b0, busy}, 32'd0);

        // ---- 6: hit on visited slot, reset mid-update
        do_reset();
        do_launch(5, 100, 200, 3, -4);
        do_launch(6, 200, 200, 0, 0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        hit_valid = 1'b1;
        hit_slot  = 3'd1;
        step();
        hit_valid = 1'b0;
        repeat (3) step();
        check("t6_hit_beats_update", slot_of(1), 32'd0);
        check("t6_slot0_updated", slot_of(0), mk_entry(5, 103, 196));
        check("t6_idle", {31'b0, busy}, 32'd0);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        check("t6_busy_mid", {31'b0, busy}, 32'd1);
        Reset = 1'b1;
        #1;
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_ready", {31'b0, launch_ready}, 32'd0);
        for (int k = 0; k < NSLOT; k++) check($sformatf("t6_rst_slot%0d", k), slot_of(k), 32'd0);
        step();
        Reset = 1'b0;
        step();
        #1;
        check("t6_ready_post", {31'b0, launch_ready}, 32'd1);
        do_frame(cyc);
        check("t6_busy_cycles_post", 32'(cyc), 32'(NSLOT));
        check("t6_slot0_post", slot_of(0), 32'd0);

        // ---- randomized run against the slot model
        do_reset();
        for (int k = 0; k < NSLOT; k++) m_id[k] = 0;
        for (int n = 0; n < 300; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 4) begin
                int id, x, y, vx, vy, fs;
                id = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 63));
                x  = int'($urandom_range(18, 657));
                y  = int'($urandom_range(0, 479));
                vx = int'($urandom_range(0, 20)) - 10;
                vy = int'($urandom_range(0, 30)) - 20;
                fs = -1;
                for (int k = NSLOT - 1; k >= 0; k--) if (m_id[k] == 0) fs = k;
                if (fs < 0) begin
                    launch_id    = 6'(id);
                    launch_valid = 1'b1;
                    #1;
                    check($sformatf("rnd%0d_ready_full", n), {31'b0, launch_ready}, 32'd0);
                    launch_valid = 1'b0;
                    step();
                end else begin
                    do_launch(id, x, y, vx, vy);
                    if (id != 0) begin
                        m_id[fs] = id;
                        m_x[fs]  = x;
                        m_y[fs]  = y;
                        m_vx[fs] = vx;
                        m_vy[fs] = vy;
                    end
                end
            end else if (op < 6) begin
                int s;
                s = int'($urandom_range(0, 7));
                hit_valid = 1'b1;
                hit_slot  = 3'(s);
                step();
                hit_valid = 1'b0;
                if (s < NSLOT) m_id[s] = 0;
            end else begin
                do_frame(cyc);
                check($sformatf("rnd%0d_busy", n), 32'(cyc), 32'(NSLOT));
                model_frame();
            end
            for (int k = 0; k < NSLOT; k++) begin
                check($sformatf("rnd%0d_slot%0d", n, k), slot_of(k),
                      (m_id[k] != 0) ? mk_entry(m_id[k], m_x[k], m_y[k]) : 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
